// File: rtl/count_arb.sv
// Round-robin sequencer that lends one shared W-bit tick counter to NREQ requesters.
// A winner runs for its latched length in tick-high cycles, then gets a one-cycle done pulse.
module count_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic              tick,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_cnt;
  logic [W-1:0]    r_len;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_idx;

  logic [PW-1:0]   w_win;
  logic [W-1:0]    w_winLen;
  logic [PW-1:0]   w_nextPtr;

  // Search starts at the priority pointer and wraps, so the last winner goes to the back.
  always_comb begin : winSel
    int   j;
    logic found;
    w_win = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        w_win = PW'(j);
      end
    end
  end

  assign w_winLen  = len[w_win*W +: W];
  assign w_nextPtr = (r_idx == PW'(NREQ-1)) ? '0 : r_idx + PW'(1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (req != '0) begin
            r_gnt <= NREQ'(1) << w_win;
            r_idx <= w_win;
            r_len <= w_winLen;
            if (w_winLen == '0) begin
              r_state <= DONE;
              r_done  <= NREQ'(1) << w_win;
            end else begin
              r_state <= COUNT;
            end
          end
        end
        COUNT: begin
          // Withdrawal takes precedence over a final tick arriving on the same edge.
          if (!req[r_idx]) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= w_nextPtr;
          end else if (tick) begin
            r_cnt <= r_cnt + W'(1);
            if (r_cnt == r_len - W'(1)) begin
              r_state <= DONE;
              r_done  <= r_gnt;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_cnt   <= '0;
          r_ptr   <= w_nextPtr;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign cnt  = r_cnt;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_count_arb.sv
// Randomized bench for count_arb: every cycle the outputs are compared against a
// transaction-level model that tracks owner, ticks served and the priority pointer.
module tb_count_arb;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk;
  logic              clr;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] len;
  logic              tick;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      cnt;

  int checkCount;
  int failCount;

  // Model: owner -1 means nobody holds the counter.
  int mOwner;
  int mLen;
  int mCnt;
  int mPtr;
  bit mInDone;

  count_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .clr(clr), .req(req), .len(len), .tick(tick),
    .gnt(gnt), .busy(busy), .done(done), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: serve the first pending requester from the pointer onward,
  // finish after L ticks (or at once for L=0), release on withdrawal.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mOwner  = -1;
      mLen    = 0;
      mCnt    = 0;
      mPtr    = 0;
      mInDone = 0;
    end else if (mInDone) begin
      mPtr    = (mOwner + 1) % NREQ;
      mOwner  = -1;
      mCnt    = 0;
      mInDone = 0;
    end else if (mOwner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (mPtr + k) % NREQ;
        if (mOwner < 0 && req[c]) mOwner = c;
      end
      if (mOwner >= 0) begin
        mLen    = int'(len[mOwner*W +: W]);
        mCnt    = 0;
        mInDone = (mLen == 0);
      end
    end else if (!req[mOwner]) begin
      mPtr   = (mOwner + 1) % NREQ;
      mOwner = -1;
      mCnt   = 0;
    end else if (tick) begin
      mCnt = mCnt + 1;
      if (mCnt == mLen) mInDone = 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ed;
    eg = (mOwner >= 0) ? (NREQ'(1) << mOwner) : '0;
    ed = mInDone ? eg : '0;
    checkOutput("gnt",  32'(gnt),  32'(eg));
    checkOutput("done", 32'(done), 32'(ed));
    checkOutput("cnt",  32'(cnt),  32'(mCnt));
    checkOutput("busy", 32'(busy), 32'(mOwner >= 0));
  endtask

  // Requesters hold their level until served; a few withdraw mid-run, lengths drift.
  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i]) begin
        len[i*W +: W] = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 4));
        if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
      end else if (mInDone && mOwner == i) begin
        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        req[i] = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        len[i*W +: W] = W'($urandom_range(0, 15));
      end
    end
    tick = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulseReset();
    #2 clr = 1'b1;
    #1;
    checkOutput("rst_gnt",  32'(gnt),  32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_cnt",  32'(cnt),  32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    #1 clr = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    clr  = 1'b0;
    req  = '0;
    len  = '0;
    tick = 1'b0;
    @(negedge clk);
    pulseReset();

    // Round-robin with all requesters pending and unit lengths.
    @(negedge clk);
    req  = '1;
    len  = {NREQ{W'(1)}};
    tick = 1'b1;
    repeat (20) begin
      @(negedge clk);
      compareAll();
    end

    // Zero-length request goes straight to completion.
    req = '0;
    repeat (3) @(negedge clk);
    compareAll();
    len[2*W +: W] = '0;
    req = 4'b0100;
    repeat (4) begin
      @(negedge clk);
      compareAll();
    end
    req = '0;

    // Reset in the middle of a long run.
    len[0 +: W] = W'(5);
    req = 4'b0001;
    repeat (5) begin
      @(negedge clk);
      compareAll();
    end
    pulseReset();
    repeat (3) begin
      @(negedge clk);
      compareAll();
    end

    // Randomized traffic with occasional asynchronous resets.
    req = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      compareAll();
      if ($urandom_range(0, 299) == 0) pulseReset();
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
